pll_ctrl: RTL
=============

Name: pll_ctrl

Overview:
- Configuration and lock-supervision controller that drives a pll instance.
- Takes divider-change requests over a valid/ready handshake and drives ref_div/fb_div to the PLL.
- Waits for the PLL's lock indication, then raises a clock-enable for downstream gating.
- Reports lock-acquisition timeout and loss of lock.
- Runs in the reference-clock domain and synchronizes the PLL's locked output internally.

Parameters:
REF_DEV_WIDTH, 4, width of reference divider (matches pll)
FB_DIV_WIDTH, 8, width of feedback divider (matches pll)
RESET_REF_DIV, 1, ref divider driven from reset
RESET_FB_DIV, 1, fb divider driven from reset
SETTLE_CYCLES, 8, cycles the lock input is ignored after any divider change (>=1)
LOCK_TIMEOUT, 40000, max cycles in WAIT_LOCK before FAIL (>=1)

Ports:
clk_i  in  1  reference clock; the block's only clock; same net as the pll clk_ref_i
arst_ni  in  1  asynchronous active-low reset
req_valid_i  in  1  new divider request valid
req_ready_o  out  1  request can be accepted
req_ref_div_i  in  REF_DEV_WIDTH  requested ref divider
req_fb_div_i  in  FB_DIV_WIDTH  requested fb divider
ref_div_o  out  REF_DEV_WIDTH  to pll ref_div_i
fb_div_o  out  FB_DIV_WIDTH  to pll fb_div_i
pll_locked_i  in  1  pll locked_o; asynchronous to clk_i
locked_o  out  1  synchronized, qualified lock status
clk_en_o  out  1  downstream clock-gate enable
busy_o  out  1  high in SETTLE or WAIT_LOCK
timeout_o  out  1  sticky lock-timeout flag
lock_lost_o  out  1  one-cycle pulse on unsolicited lock loss

Behaviour:
- Reset state: SETTLE, loaded with SETTLE_CYCLES.
- Reset output values: ref_div_o=RESET_REF_DIV, fb_div_o=RESET_FB_DIV, req_ready_o=0, locked_o=0, clk_en_o=0, busy_o=1, timeout_o=0, lock_lost_o=0, synchronizer flops=0.
- Reset is asynchronous. Assertion mid-operation forces reset values immediately, whatever the state.
- pll_locked_i passes through a 2-flop synchronizer (lock_s). Latency is 2 cycles.
- States:
  - SETTLE: counter decrements each cycle; lock_s is ignored. Go to WAIT_LOCK on the cycle the counter reaches 0, with the timeout counter loaded to LOCK_TIMEOUT.
  - WAIT_LOCK: if lock_s=1, go to LOCKED. Otherwise decrement the timeout counter; at 0, go to FAIL and set timeout_o.
  - LOCKED: locked_o=1 and clk_en_o=1, both registered and asserted on the first cycle in LOCKED. If lock_s=0, pulse lock_lost_o for one cycle, deassert locked_o and clk_en_o, and go to WAIT_LOCK with a fresh timeout.
  - FAIL: outputs hold; waits for a request. There is no autonomous retry.
- Handshake:
  - req_ready_o=1 in LOCKED and FAIL only, registered from state.
  - Transfer occurs when req_valid_i & req_ready_o at a rising edge.
  - On the next cycle: ref_div_o and fb_div_o take the request, locked_o=0, clk_en_o=0, timeout_o=0, state=SETTLE, req_ready_o=0.
  - Requests in SETTLE/WAIT_LOCK are stalled, not dropped.
- Zero divider field: the field is clamped to 1 when registered, so ref_div_o and fb_div_o are never 0.
- Request identical to the current dividers: still accepted and runs the full SETTLE/WAIT_LOCK sequence.
- Simultaneous accept and lock_s fall in LOCKED: the request wins and lock_lost_o stays 0.
- lock_s=1 on the same edge the timeout counter reaches 0: the lock wins and the state goes to LOCKED.
- Dividers change only on a handshake or reset. They are held stable in every other state so the pll's internal stability detector sees no glitch.
- Counter widths:
  - settle counter: $clog2(SETTLE_CYCLES+1)
  - timeout counter: $clog2(LOCK_TIMEOUT+1)
  - Both saturate at 0; no wrap.

Decomposition:
- Package pll_ctrl_pkg: enum pll_ctrl_state_e {SETTLE, WAIT_LOCK, LOCKED, FAIL}; localparam helpers for counter widths.
- One sub-module: sync_2ff (parameterized-width 2-flop synchronizer, clk_i/arst_ni, reset value 0), reusable elsewhere.
- Counters and FSM stay in pll_ctrl.

Test Plan:
- Lock after reset: SETTLE_CYCLES=8; release arst_ni; pll_locked_i rises at cycle 20 -> locked_o and clk_en_o rise at cycle 23. busy_o is 1 in cycles 0-22. req_ready_o rises at cycle 23.
- Divider change: in LOCKED, request ref=2 fb=10 -> next cycle ref_div_o=2, fb_div_o=10, clk_en_o=0, req_ready_o=0. Then 8 cycles of SETTLE, then WAIT_LOCK. Relock follows pll_locked_i with 2-cycle plus FSM latency.
- Timeout: LOCK_TIMEOUT=100; pll_locked_i held 0 -> FAIL and timeout_o=1 exactly 8+100 cycles after entering SETTLE. req_ready_o=1. A new request clears timeout_o.
- Lock loss: in LOCKED, drop pll_locked_i -> lock_lost_o single-cycle pulse 3 cycles later, with clk_en_o/locked_o low the same cycle. State is WAIT_LOCK; re-raising the lock returns to LOCKED.
- Edge cases:
  - Zero-divider request ref=0 fb=0 -> ref_div_o=1, fb_div_o=1.
  - Request accepted on the same edge lock_s falls -> no lock_lost_o pulse.
- Reset mid-operation: assert arst_ni low in WAIT_LOCK between clock edges -> all outputs at reset values and dividers = RESET_* before the next edge. After release, SETTLE restarts.

Source files
------------

// File: rtl/pll_ctrl_pkg.sv
// Shared types and helpers for the PLL configuration / lock-supervision controller.
package pll_ctrl_pkg;

   typedef enum logic [1:0] {
      SETTLE    = 2'd0,
      WAIT_LOCK = 2'd1,
      LOCKED    = 2'd2,
      FAIL      = 2'd3
   } pll_ctrl_state_e;

   // Width of a down-counter that must hold values 0..max_val.
   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for bringing asynchronous levels into the clk_i domain.
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk_i,
   input  logic             arst_ni,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] meta_q, meta_d;
   logic [WIDTH-1:0] sync_q, sync_d;

   // Shift the async level through two stages.
   always_comb begin
      meta_d = d_i;
      sync_d = meta_q;
   end

   // Synchronizer flops, cleared on reset.
   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/pll_ctrl.sv
// PLL divider configuration and lock supervision: accepts divider requests,
// waits out a settle window, watches the synchronized lock, gates the clock.
module pll_ctrl
   import pll_ctrl_pkg::*;
#(
   parameter int REF_DEV_WIDTH = 4,
   parameter int FB_DIV_WIDTH  = 8,
   parameter int RESET_REF_DIV = 1,
   parameter int RESET_FB_DIV  = 1,
   parameter int SETTLE_CYCLES = 8,
   parameter int LOCK_TIMEOUT  = 40000
) (
   input  logic                     clk_i,
   input  logic                     arst_ni,
   input  logic                     req_valid_i,
   output logic                     req_ready_o,
   input  logic [REF_DEV_WIDTH-1:0] req_ref_div_i,
   input  logic [FB_DIV_WIDTH-1:0]  req_fb_div_i,
   output logic [REF_DEV_WIDTH-1:0] ref_div_o,
   output logic [FB_DIV_WIDTH-1:0]  fb_div_o,
   input  logic                     pll_locked_i,
   output logic                     locked_o,
   output logic                     clk_en_o,
   output logic                     busy_o,
   output logic                     timeout_o,
   output logic                     lock_lost_o
);

   localparam int SW = cnt_width(SETTLE_CYCLES);
   localparam int TW = cnt_width(LOCK_TIMEOUT);
   localparam logic [SW-1:0] SETTLE_INIT = SW'(SETTLE_CYCLES);
   localparam logic [TW-1:0] TMO_INIT    = TW'(LOCK_TIMEOUT);

   pll_ctrl_state_e state_q, state_d;
   logic [SW-1:0] settle_cnt_q, settle_cnt_d;
   logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
   logic [REF_DEV_WIDTH-1:0] ref_div_q, ref_div_d;
   logic [FB_DIV_WIDTH-1:0]  fb_div_q, fb_div_d;
   logic ready_q, ready_d;
   logic locked_q, locked_d;
   logic busy_q, busy_d;
   logic timeout_q, timeout_d;
   logic lost_q, lost_d;
   logic lock_s;
   logic accept;

   sync_2ff #(.WIDTH(1)) u_lock_sync (
      .clk_i   (clk_i),
      .arst_ni (arst_ni),
      .d_i     (pll_locked_i),
      .q_o     (lock_s)
   );

   // A request transfers only while the registered ready is high.
   assign accept = req_valid_i & ready_q;

   // State register plus counters and registered outputs.
   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         state_q      <= SETTLE;
         settle_cnt_q <= SETTLE_INIT;
         tmo_cnt_q    <= TMO_INIT;
         ref_div_q    <= REF_DEV_WIDTH'(RESET_REF_DIV);
         fb_div_q     <= FB_DIV_WIDTH'(RESET_FB_DIV);
         ready_q      <= 1'b0;
         locked_q     <= 1'b0;
         busy_q       <= 1'b1;
         timeout_q    <= 1'b0;
         lost_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         settle_cnt_q <= settle_cnt_d;
         tmo_cnt_q    <= tmo_cnt_d;
         ref_div_q    <= ref_div_d;
         fb_div_q     <= fb_div_d;
         ready_q      <= ready_d;
         locked_q     <= locked_d;
         busy_q       <= busy_d;
         timeout_q    <= timeout_d;
         lost_q       <= lost_d;
      end
   end

   // Next state and counters; an accepted request overrides everything, and
   // a lock seen on the last timeout cycle beats the timeout.
   always_comb begin
      state_d      = state_q;
      settle_cnt_d = settle_cnt_q;
      tmo_cnt_d    = tmo_cnt_q;
      if (accept) begin
         state_d      = SETTLE;
         settle_cnt_d = SETTLE_INIT;
      end else begin
         case (state_q)
            SETTLE: begin
               if (settle_cnt_q != '0) settle_cnt_d = settle_cnt_q - SW'(1);
               if (settle_cnt_q <= SW'(1)) begin
                  state_d   = WAIT_LOCK;
                  tmo_cnt_d = TMO_INIT;
               end
            end
            WAIT_LOCK: begin
               if (lock_s) begin
                  state_d = LOCKED;
               end else begin
                  if (tmo_cnt_q != '0) tmo_cnt_d = tmo_cnt_q - TW'(1);
                  if (tmo_cnt_q <= TW'(1)) state_d = FAIL;
               end
            end
            LOCKED: begin
               if (!lock_s) begin
                  state_d   = WAIT_LOCK;
                  tmo_cnt_d = TMO_INIT;
               end
            end
            default: state_d = state_q;
         endcase
      end
   end

   // Output flop inputs decoded from the next state so outputs align with it.
   always_comb begin
      ready_d   = (state_d == LOCKED) || (state_d == FAIL);
      locked_d  = (state_d == LOCKED);
      busy_d    = (state_d == SETTLE) || (state_d == WAIT_LOCK);
      lost_d    = (state_q == LOCKED) && !lock_s && !accept;
      timeout_d = timeout_q;
      ref_div_d = ref_div_q;
      fb_div_d  = fb_div_q;
      if (accept) begin
         timeout_d = 1'b0;
         // A zero divider would stall the PLL, so clamp it to 1.
         ref_div_d = (req_ref_div_i == '0) ? REF_DEV_WIDTH'(1) : req_ref_div_i;
         fb_div_d  = (req_fb_div_i == '0) ? FB_DIV_WIDTH'(1) : req_fb_div_i;
      end else if ((state_q == WAIT_LOCK) && (state_d == FAIL)) begin
         timeout_d = 1'b1;
      end
   end

   assign req_ready_o = ready_q;
   assign ref_div_o   = ref_div_q;
   assign fb_div_o    = fb_div_q;
   assign locked_o    = locked_q;
   assign clk_en_o    = locked_q;
   assign busy_o      = busy_q;
   assign timeout_o   = timeout_q;
   assign lock_lost_o = lost_q;

endmodule
